countdown_timer: RTL and testbench
==================================

# countdown_timer

Parametrised mm:ss countdown timer for the DE-series board top level, successor to the single-purpose state-machine timer. The operator programs seconds and then minutes from the switches, starts and stops the count with a button, and gets a flashing LED alarm at 00:00. The block drives the four seven-segment digits and the red LEDs directly; the tick rate and flash rate are parameters so simulation can run with short periods.

## Interface
- `TICK_CYCLES`, 50_000_000: CLOCK_50 cycles per one-second tick.
- `FLASH_CYCLES`, 25_000_000: CLOCK_50 cycles per LED flash phase.
- `MAX_MIN`, 99: largest programmable minutes value (1..99).

- `CLOCK_50`  in  1  sole clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `SW`  in  8  unsigned binary value to program.
- `set_btn`  in  1  level, active-high, already debounced and synchronised.
- `toggle_btn`  in  1  level, active-high, already debounced and synchronised.
- `LEDR`  out  10  status and alarm LEDs.
- `HEX0`..`HEX3`  out  7 each  active-low segments {g,f,e,d,c,b,a}: seconds units, seconds tens, minutes units, minutes tens.

## Operation
- **Button events:** each button is registered internally. A press event is a rising edge (1 after 0). It is 1 cycle wide and is acted on in the cycle after the edge. Holding a button produces one event only.
- **Simultaneous events:** set has priority, and toggle is dropped.
- **State register:** `sec` (0..59) and `min` (0..MAX_MIN) are binary registers. The prescaler runs 0..TICK_CYCLES-1.
- **States:** IDLE=0, SET_SEC=1, SET_MIN=2, STOPPED=3, RUNNING=4, FLASH=5.
- **IDLE:** clears `sec`, `min` and the prescaler, then moves unconditionally to SET_SEC on the next cycle.
- **SET_SEC:**
  - set event: `sec` <= min(SW, 59), then SET_MIN.
  - toggle is ignored.
- **SET_MIN:**
  - set event: `min` <= min(SW, MAX_MIN), then STOPPED.
  - toggle is ignored.
- **STOPPED:**
  - toggle event with time ≠ 00:00: go to RUNNING.
  - toggle event with time = 00:00: ignored.
  - set event: go to SET_SEC and clear the prescaler. Time is kept until overwritten.
- **RUNNING:**
  - The prescaler increments each cycle. At TICK_CYCLES-1 it wraps to 0 and issues a tick.
  - Tick with `sec`>0: `sec`-1.
  - Tick with `sec`=0: `min`-1 and `sec`=59.
  - If the post-decrement time is 00:00, go to FLASH in that same update.
  - toggle event: go to STOPPED. The prescaler is held, not cleared, so the partial second is kept.
  - set event: ignored.
- **FLASH:**
  - A flash counter runs 0..FLASH_CYCLES-1. On each wrap the phase bit inverts.
  - toggle event (acknowledge): go to IDLE.
  - set event: ignored.
- **LEDR:**
  - FLASH: all 10 bits = phase.
  - All other states: LEDR[2:0] = state code and LEDR[9:3] = 0.
- **Displays:** show the registered `min`/`sec` converted to decimal digits. They do not preview SW.
- **Reset mid-operation:** reset in any state, including mid-tick or mid-flash, wins over all events. On the following cycle the state is IDLE.

## Timing
- Reset values:
  - State IDLE; `sec`=`min`=0; prescaler, flash counter and phase = 0; button registers = 0.
  - LEDR = 10'b0; HEX0..HEX3 = 7'b1000000 ("0").
- Outputs are registered:
  - The display update follows the `sec`/`min` change by 1 cycle.
  - LEDR follows a state or phase change by 1 cycle.
- Latencies:
  - Button edge to state change: 2 cycles.
  - RUNNING entry to first tick: TICK_CYCLES cycles when the prescaler is 0.
- Phase starts at 0 on FLASH entry, so the first toggle of all LEDs is FLASH_CYCLES cycles after entry.

## Configuration
- `TIMER_FLASH_EN` defined: FLASH behaves as described above.
- `TIMER_FLASH_EN` undefined:
  - The flash counter is removed.
  - In FLASH, LEDR is held at 10'h3FF, solid.
  - FLASH exit via toggle is unchanged.

## Structure
- Package `timer_pkg`:
  - state enum/localparams (IDLE..FLASH, 3 bits);
  - the 59 seconds limit;
  - the seven-segment blank/zero constants.
- Sub-module `seg7_decoder`: combinational, 4-bit digit in, 7-bit active-low segments out. Instantiated 4 times.
- Binary-to-decimal digit split (/10, %10) is done in `countdown_timer`.

## Test plan
Benches use TICK_CYCLES=4 and FLASH_CYCLES=3.

- Reset held 2 cycles, then released: state reaches SET_SEC, LEDR=10'b1, and all HEX = 7'b1000000.
- Programming with clamping:
  - SW=75, set event: `sec`=59.
  - SW=120 with MAX_MIN=99, set event: `min`=99.
  - Result: HEX3..0 show 9,9,5,9 and the state is STOPPED.
- Program 00:02, then toggle: ticks give 00:01 at +4 cycles and 00:00 at +8 cycles. FLASH is entered in the same update, and LEDR alternates 3FF/000 every 3 cycles.
- Program 01:00, then run 1 tick: display shows 00:59.
- Stop/resume: toggle at prescaler=2 stops the count. After 10 idle cycles, toggle resumes, and the next tick arrives 2 cycles later.
- Corner events:
  - set and toggle in the same cycle in STOPPED: goes to SET_SEC.
  - toggle at 00:00 in STOPPED: no change.
  - reset during FLASH: next cycle is IDLE with LEDR=0.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_SEC = 3'd1,
    SET_MIN = 3'd2,
    STOPPED = 3'd3,
    RUNNING = 3'd4,
    FLASH   = 3'd5
  } state_t;

  localparam logic [5:0] SEC_LIMIT = 6'd59;

  // Active-low segment patterns ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic logic [5:0] clamp_sec(input logic [7:0] value);
    return (value > {2'b00, SEC_LIMIT}) ? SEC_LIMIT : value[5:0];
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Board-facing signal bundle of the countdown timer: switches, buttons, LEDs, displays.
interface countdown_timer_if;

  logic [7:0] SW;
  logic       set_btn;
  logic       toggle_btn;
  logic [9:0] LEDR;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;

  modport master (
    output SW, set_btn, toggle_btn,
    input  LEDR, HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  SW, set_btn, toggle_btn,
    output LEDR, HEX0, HEX1, HEX2, HEX3
  );

endinterface

// File: rtl/countdown_timer_seg7_decoder.sv
// Decimal digit to active-low seven-segment pattern; codes above 9 blank the digit.
module seg7_decoder
  import timer_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (digit)
      4'd0: segments = SEG_ZERO;
      4'd1: segments = 7'b1111001;
      4'd2: segments = 7'b0100100;
      4'd3: segments = 7'b0110000;
      4'd4: segments = 7'b0011001;
      4'd5: segments = 7'b0010010;
      4'd6: segments = 7'b0000010;
      4'd7: segments = 7'b1111000;
      4'd8: segments = 7'b0000000;
      4'd9: segments = 7'b0010000;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// Programmable mm:ss countdown timer with LED alarm; define TIMER_FLASH_EN for a
// flashing alarm, otherwise the alarm LEDs are lit solid.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_CYCLES  = 50_000_000,
  parameter int FLASH_CYCLES = 25_000_000,
  parameter int MAX_MIN      = 99
)(
  input  logic               CLOCK_50,
  input  logic               reset,
  countdown_timer_if.slave   bus
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [6:0]    MIN_LIMIT  = 7'(MAX_MIN);

  state_t        state, state_nx;
  logic [5:0]    sec, sec_nx;
  logic [6:0]    min, min_nx;
  logic [PW-1:0] presc, presc_nx;

  logic set_q, toggle_q;
  logic set_ev, toggle_ev;

  logic [9:0] ledr_q, ledr_nx;
  logic [6:0] hex0_q, hex1_q, hex2_q, hex3_q;
  logic [6:0] seg_sec_u, seg_sec_t, seg_min_u, seg_min_t;

  // Edge events are registered; a toggle coinciding with a set is dropped
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      set_q     <= 1'b0;
      toggle_q  <= 1'b0;
      set_ev    <= 1'b0;
      toggle_ev <= 1'b0;
    end else begin
      set_q     <= bus.set_btn;
      toggle_q  <= bus.toggle_btn;
      set_ev    <= bus.set_btn & ~set_q;
      toggle_ev <= bus.toggle_btn & ~toggle_q & ~(bus.set_btn & ~set_q);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      sec   <= '0;
      min   <= '0;
      presc <= '0;
    end else begin
      state <= state_nx;
      sec   <= sec_nx;
      min   <= min_nx;
      presc <= presc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sec_nx   = sec;
    min_nx   = min;
    presc_nx = presc;
    case (state)
      IDLE: begin
        sec_nx   = '0;
        min_nx   = '0;
        presc_nx = '0;
        state_nx = SET_SEC;
      end
      SET_SEC: begin
        if (set_ev) begin
          sec_nx   = clamp_sec(bus.SW);
          state_nx = SET_MIN;
        end
      end
      SET_MIN: begin
        if (set_ev) begin
          min_nx   = (bus.SW > {1'b0, MIN_LIMIT}) ? MIN_LIMIT : bus.SW[6:0];
          state_nx = STOPPED;
        end
      end
      STOPPED: begin
        if (set_ev) begin
          presc_nx = '0;
          state_nx = SET_SEC;
        end else if (toggle_ev && (sec != 6'd0 || min != 7'd0)) begin
          state_nx = RUNNING;
        end
      end
      RUNNING: begin
        // Stopping freezes the prescaler so the partial second survives a pause
        if (toggle_ev) begin
          state_nx = STOPPED;
        end else if (presc == PRESC_LAST) begin
          presc_nx = '0;
          if (sec != 6'd0) begin
            sec_nx = sec - 6'd1;
          end else begin
            sec_nx = SEC_LIMIT;
            min_nx = min - 7'd1;
          end
          if (sec_nx == 6'd0 && min_nx == 7'd0) state_nx = FLASH;
        end else begin
          presc_nx = presc + PW'(1);
        end
      end
      FLASH: begin
        if (toggle_ev) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef TIMER_FLASH_EN
  localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);

  logic [FW-1:0] flash_cnt, flash_nx;
  logic          phase, phase_nx;

  // Counter and phase rest at zero outside FLASH so every alarm starts dark
  always_comb begin
    flash_nx = '0;
    phase_nx = 1'b0;
    if (state == FLASH) begin
      if (flash_cnt == FLASH_LAST) begin
        flash_nx = '0;
        phase_nx = ~phase;
      end else begin
        flash_nx = flash_cnt + FW'(1);
        phase_nx = phase;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      flash_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      flash_cnt <= flash_nx;
      phase     <= phase_nx;
    end
  end
`else
  logic unused_flash_cycles;
  assign unused_flash_cycles = (FLASH_CYCLES > 0);
`endif

  always_comb begin
    ledr_nx = {7'b0, state};
    if (state == FLASH) begin
`ifdef TIMER_FLASH_EN
      ledr_nx = {10{phase}};
`else
      ledr_nx = 10'h3FF;
`endif
    end
  end

  seg7_decoder u_sec_units (.digit(4'(sec % 6'd10)), .segments(seg_sec_u));
  seg7_decoder u_sec_tens  (.digit(4'(sec / 6'd10)), .segments(seg_sec_t));
  seg7_decoder u_min_units (.digit(4'(min % 7'd10)), .segments(seg_min_u));
  seg7_decoder u_min_tens  (.digit(4'(min / 7'd10)), .segments(seg_min_t));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ledr_q <= '0;
      hex0_q <= SEG_ZERO;
      hex1_q <= SEG_ZERO;
      hex2_q <= SEG_ZERO;
      hex3_q <= SEG_ZERO;
    end else begin
      ledr_q <= ledr_nx;
      hex0_q <= seg_sec_u;
      hex1_q <= seg_sec_t;
      hex2_q <= seg_min_u;
      hex3_q <= seg_min_t;
    end
  end

  assign bus.LEDR = ledr_q;
  assign bus.HEX0 = hex0_q;
  assign bus.HEX1 = hex1_q;
  assign bus.HEX2 = hex2_q;
  assign bus.HEX3 = hex3_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with short tick/flash periods; honours TIMER_FLASH_EN.
module tb_countdown_timer;

  logic clk;
  logic reset;
  int   vec_count;
  int   err_count;
  logic [6:0] seg_lut [10];
  logic [9:0] alarm_dark;

  countdown_timer_if bus ();

  countdown_timer #(
    .TICK_CYCLES (4),
    .FLASH_CYCLES(3),
    .MAX_MIN     (99)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Hold the buttons for one sampled edge, then release them
  task automatic applyStimulus(input logic s, input logic t, input logic [7:0] sw);
    bus.SW         = sw;
    bus.set_btn    = s;
    bus.toggle_btn = t;
    step(1);
    bus.set_btn    = 1'b0;
    bus.toggle_btn = 1'b0;
  endtask

  task automatic press(input logic s, input logic t, input logic [7:0] sw);
    applyStimulus(s, t, sw);
    step(2);
  endtask

  task automatic checkTime(input string tag, input int m, input int s);
    checkOutput({tag, "_hex3"}, 32'(bus.HEX3), 32'(seg_lut[m / 10]));
    checkOutput({tag, "_hex2"}, 32'(bus.HEX2), 32'(seg_lut[m % 10]));
    checkOutput({tag, "_hex1"}, 32'(bus.HEX1), 32'(seg_lut[s / 10]));
    checkOutput({tag, "_hex0"}, 32'(bus.HEX0), 32'(seg_lut[s % 10]));
  endtask

  initial begin
    seg_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef TIMER_FLASH_EN
    alarm_dark = 10'h000;
`else
    alarm_dark = 10'h3FF;
`endif
    vec_count      = 0;
    err_count      = 0;
    reset          = 1'b1;
    bus.SW         = 8'd0;
    bus.set_btn    = 1'b0;
    bus.toggle_btn = 1'b0;

    $display("[TB] reset");
    step(2);
    checkOutput("reset_ledr", 32'(bus.LEDR), 32'h0);
    checkTime("reset", 0, 0);
    reset = 1'b0;
    step(2);
    checkOutput("set_sec_ledr", 32'(bus.LEDR), 32'h1);

    $display("[TB] programming with clamping");
    press(1'b1, 1'b0, 8'd75);
    checkOutput("after_sec_ledr", 32'(bus.LEDR), 32'h2);
    press(1'b1, 1'b0, 8'd120);
    checkOutput("stopped_ledr", 32'(bus.LEDR), 32'h3);
    checkTime("clamp", 99, 59);

    $display("[TB] 00:02 countdown to alarm");
    press(1'b1, 1'b0, 8'd0);
    press(1'b1, 1'b0, 8'd2);
    press(1'b1, 1'b0, 8'd0);
    checkTime("prog_0002", 0, 2);
    applyStimulus(1'b0, 1'b1, 8'd0);
    step(2);
    checkOutput("running_ledr", 32'(bus.LEDR), 32'h4);
    step(3);
    checkOutput("pre_tick1", 32'(bus.HEX0), 32'(seg_lut[2]));
    step(1);
    checkOutput("tick1", 32'(bus.HEX0), 32'(seg_lut[1]));
    step(3);
    checkOutput("pre_flash_ledr", 32'(bus.LEDR), 32'h4);
    step(1);
    checkTime("tick2", 0, 0);
    checkOutput("flash_entry", 32'(bus.LEDR), 32'(alarm_dark));
    step(2);
    checkOutput("flash_e3", 32'(bus.LEDR), 32'(alarm_dark));
    step(1);
    checkOutput("flash_e4", 32'(bus.LEDR), 32'h3FF);
    step(3);
    checkOutput("flash_e7", 32'(bus.LEDR), 32'(alarm_dark));

    $display("[TB] acknowledge alarm");
    press(1'b0, 1'b1, 8'd0);
    checkOutput("ack_idle", 32'(bus.LEDR), 32'h0);
    step(1);
    checkOutput("ack_set_sec", 32'(bus.LEDR), 32'h1);

    $display("[TB] 01:00 borrow");
    press(1'b1, 1'b0, 8'd0);
    press(1'b1, 1'b0, 8'd1);
    checkTime("prog_0100", 1, 0);
    applyStimulus(1'b0, 1'b1, 8'd0);
    step(6);
    checkTime("borrow", 0, 59);
    checkOutput("borrow_ledr", 32'(bus.LEDR), 32'h4);

    $display("[TB] stop and resume");
    applyStimulus(1'b0, 1'b1, 8'd0);
    step(10);
    checkOutput("paused_ledr", 32'(bus.LEDR), 32'h3);
    checkOutput("paused_hex0", 32'(bus.HEX0), 32'(seg_lut[9]));
    applyStimulus(1'b0, 1'b1, 8'd0);
    step(2);
    checkOutput("resumed_ledr", 32'(bus.LEDR), 32'h4);
    step(1);
    checkOutput("resume_pre_tick", 32'(bus.HEX0), 32'(seg_lut[9]));
    step(1);
    checkTime("resume_tick", 0, 58);

    $display("[TB] corner events");
    press(1'b0, 1'b1, 8'd0);
    checkOutput("stop_again", 32'(bus.LEDR), 32'h3);
    press(1'b1, 1'b1, 8'd0);
    checkOutput("set_wins", 32'(bus.LEDR), 32'h1);
    checkTime("time_kept", 0, 58);
    press(1'b1, 1'b0, 8'd0);
    press(1'b1, 1'b0, 8'd0);
    checkTime("prog_0000", 0, 0);
    press(1'b0, 1'b1, 8'd0);
    checkOutput("zero_toggle", 32'(bus.LEDR), 32'h3);
    step(4);
    checkOutput("zero_toggle_late", 32'(bus.LEDR), 32'h3);

    $display("[TB] reset during alarm");
    press(1'b1, 1'b0, 8'd0);
    press(1'b1, 1'b0, 8'd1);
    press(1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'd0);
    step(6);
    checkOutput("alarm2_entry", 32'(bus.LEDR), 32'(alarm_dark));
    step(1);
    reset = 1'b1;
    step(1);
    checkOutput("reset_flash_ledr", 32'(bus.LEDR), 32'h0);
    reset = 1'b0;
    step(1);
    checkOutput("post_reset_idle", 32'(bus.LEDR), 32'h0);
    step(1);
    checkOutput("post_reset_set_sec", 32'(bus.LEDR), 32'h1);
    checkTime("post_reset", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
